// File: rtl/circuit_test_pkg.sv
// Shared types and helpers for the evolved-circuit test sequencer.
// Optional Gray-order vector sequencing is selected with CTS_GRAY_ORDER_EN.
package circuit_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    EVAL,
    DONE
  } cts_state_t;

  // Settle must cover the 2-flop synchronizer; instability needs two samples.
  localparam int CTS_MIN_SETTLE  = 3;
  localparam int CTS_MIN_SAMPLES = 2;

  function automatic logic [31:0] gray_code(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer bringing the raw circuit-under-test output into clk.
module bit_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/circuit_test_sequencer.sv
// Sweeps every input vector of an asynchronous circuit, checks stability and truth table.
// Define CTS_GRAY_ORDER_EN to apply vectors in Gray order instead of ascending order.
module circuit_test_sequencer
  import circuit_test_pkg::*;
#(
  parameter int IN_WIDTH      = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_COUNT  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [(1<<IN_WIDTH)-1:0]   expected,
  input  logic                       dut_out,
  output logic [IN_WIDTH-1:0]        dut_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [(1<<IN_WIDTH)-1:0]   fail_mask,
  output logic [(1<<IN_WIDTH)-1:0]   unstable_mask,
  output cts_state_t                 dbg_state
);

  localparam int NV      = 1 << IN_WIDTH;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (SETTLE_CYCLES < CTS_MIN_SETTLE) begin : g_bad_settle
    $error("SETTLE_CYCLES below minimum");
  end
  if (SAMPLE_COUNT < CTS_MIN_SAMPLES) begin : g_bad_samples
    $error("SAMPLE_COUNT below minimum");
  end

  cts_state_t          state, state_next;
  logic [IN_WIDTH-1:0] idx;
  logic [IN_WIDTH-1:0] vec;
  logic [CW-1:0]       cnt;
  logic [NV-1:0]       exp_q;
  logic [NV-1:0]       fail_next;
  logic                first_q;
  logic                diff_q;
  logic                out_sync;

  bit_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (dut_out),
    .q     (out_sync)
  );

  // Protocol: start is a one-cycle request taken only in IDLE; done pulses
  // once per accepted start, and pass/masks stay valid until the next start.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
`ifdef CTS_GRAY_ORDER_EN
    vec = IN_WIDTH'(gray_code(32'(idx)));
`else
    vec = idx;
`endif
    fail_next      = fail_mask;
    fail_next[vec] = diff_q | (first_q ^ exp_q[vec]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   state_next = SETTLE;
      SETTLE:  if (cnt == '0) state_next = SAMPLE;
      SAMPLE:  if (cnt == '0) state_next = EVAL;
      EVAL:    state_next = (idx == '1) ? DONE : APPLY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dut_in        <= '0;
      idx           <= '0;
      cnt           <= '0;
      exp_q         <= '0;
      fail_mask     <= '0;
      unstable_mask <= '0;
      pass          <= 1'b0;
      first_q       <= 1'b0;
      diff_q        <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q         <= expected;
            fail_mask     <= '0;
            unstable_mask <= '0;
            pass          <= 1'b0;
            idx           <= '0;
          end
        end
        APPLY: begin
          dut_in <= vec;
          cnt    <= CW'(SETTLE_CYCLES - 1);
          diff_q <= 1'b0;
        end
        SETTLE: begin
          cnt <= (cnt == '0) ? CW'(SAMPLE_COUNT - 1) : cnt - 1'b1;
        end
        SAMPLE: begin
          if (cnt == CW'(SAMPLE_COUNT - 1)) first_q <= out_sync;
          else if (out_sync != first_q)     diff_q  <= 1'b1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        EVAL: begin
          fail_mask <= fail_next;
          if (diff_q) unstable_mask[vec] <= 1'b1;
          // pass is resolved here so it is already valid during the done pulse
          if (idx == '1) pass <= (fail_next == '0);
          else           idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_test_sequencer.sv
// Randomized bench for circuit_test_sequencer against a truth-table reference model.
// Build with CTS_GRAY_ORDER_EN defined to check the Gray-order variant.
module tb_circuit_test_sequencer;
  import circuit_test_pkg::*;

  localparam int IN_WIDTH      = 2;
  localparam int SETTLE_CYCLES = 8;
  localparam int SAMPLE_COUNT  = 4;
  localparam int NV            = 1 << IN_WIDTH;
  localparam int VEC_CYCLES    = 2 + SETTLE_CYCLES + SAMPLE_COUNT;
  localparam int DONE_CYCLE    = 1 + NV * VEC_CYCLES;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [NV-1:0]       expected;
  logic                dut_out;
  logic [IN_WIDTH-1:0] dut_in;
  logic                busy;
  logic                done;
  logic                pass;
  logic [NV-1:0]       fail_mask;
  logic [NV-1:0]       unstable_mask;
  cts_state_t          dbg_state;

  always #5 clk = ~clk;

  circuit_test_sequencer #(
    .IN_WIDTH      (IN_WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SAMPLE_COUNT  (SAMPLE_COUNT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .expected      (expected),
    .dut_out       (dut_out),
    .dut_in        (dut_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_mask     (fail_mask),
    .unstable_mask (unstable_mask),
    .dbg_state     (dbg_state)
  );

  // Circuit-under-test model: truth table tt, vectors in unst oscillate every clk.
  logic [NV-1:0] tt   = '0;
  logic [NV-1:0] unst = '0;
  logic          tog  = 1'b0;

  always @(posedge clk) tog <= ~tog;
  assign dut_out = unst[dut_in] ? tog : tt[dut_in];

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [NV-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int vec_order(input int k);
`ifdef CTS_GRAY_ORDER_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  // Runs one full pass; start is driven in cycle 0 and sampled at the next edge.
  task automatic run_pass(input logic [NV-1:0] expv, input bit extra_starts);
    logic [NV-1:0] f_exp;
    logic          p_exp;
    int            done_cnt;
    int            done_at;
    f_exp    = unst | (tt ^ expv);
    p_exp    = (f_exp == '0);
    done_cnt = 0;
    done_at  = -1;
    exp_q.push_back(f_exp);
    exp_q.push_back(unst);
    exp_q.push_back(NV'(p_exp));
    next_cycle();
    start    = 1'b1;
    expected = expv;
    for (int c = 1; c <= DONE_CYCLE + 3; c++) begin
      next_cycle();
      start    = extra_starts && (c == 10 || c == 40);
      expected = NV'($urandom);
      if (c == 1) check("busy_after_start", 32'(busy), 32'd1);
      for (int k = 0; k < NV; k++)
        if (c == 2 + VEC_CYCLES * k + 5)
          check("dut_in_order", 32'(dut_in), 32'(vec_order(k)));
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = c;
          check("fail_mask", 32'(fail_mask), 32'(exp_q.pop_front()));
          check("unstable_mask", 32'(unstable_mask), 32'(exp_q.pop_front()));
          check("pass_at_done", 32'(pass), 32'(exp_q.pop_front()));
        end
      end
    end
    start = 1'b0;
    if (done_cnt == 0) exp_q.delete();
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_at), 32'(DONE_CYCLE));
    check("idle_after_done", 32'(busy), 32'd0);
    check("pass_held", 32'(pass), 32'(p_exp));
    check("dut_in_held", 32'(dut_in), 32'(vec_order(NV - 1)));
  endtask

  task automatic reset_mid_pass();
    int done_seen;
    done_seen = 0;
    tt   = NV'(1);
    unst = '0;
    next_cycle();
    start    = 1'b1;
    expected = NV'(1);
    for (int c = 1; c <= 21; c++) begin
      next_cycle();
      start = 1'b0;
      if (c == 20) reset = 1'b1;
      if (c == 21) reset = 1'b0;
    end
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_dut_in", 32'(dut_in), 32'd0);
    check("rst_mid_fail", 32'(fail_mask), 32'd0);
    check("rst_mid_unstable", 32'(unstable_mask), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    for (int c = 0; c < DONE_CYCLE + 5; c++) begin
      next_cycle();
      if (done) done_seen++;
    end
    check("rst_mid_no_done", 32'(done_seen), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    expected = '0;
    do_reset();
    check("reset_dut_in", 32'(dut_in), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_fail", 32'(fail_mask), 32'd0);
    check("reset_unstable", 32'(unstable_mask), 32'd0);

    // NOR circuit, matching and mismatching truth tables
    tt = NV'(1); unst = '0;
    run_pass(NV'(4'b0001), 1'b0);
    run_pass(NV'(4'b0011), 1'b0);
    // oscillation on the all-ones vector
    unst = NV'(4'b1000);
    run_pass(NV'(4'b0001), 1'b0);
    // forced mismatch on vector 2
    unst = '0;
    run_pass(NV'(4'b0101), 1'b0);
    // starts during a pass must be ignored
    run_pass(NV'(4'b0001), 1'b1);

    // start and reset together: reset wins
    reset = 1'b1; start = 1'b1;
    next_cycle();
    reset = 1'b0; start = 1'b0;
    check("start_with_reset", 32'(busy), 32'd0);
    next_cycle();
    check("start_with_reset_hold", 32'(busy), 32'd0);

    reset_mid_pass();
    tt = NV'(1); unst = '0;
    run_pass(NV'(4'b0001), 1'b0);

    // randomized circuits, expectations and instabilities
    for (int r = 0; r < 8; r++) begin
      tt   = NV'($urandom);
      unst = ($urandom_range(0, 2) == 0) ? NV'($urandom) : '0;
      run_pass(NV'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
